// File: rtl/bottom_mux_stage.sv
// rtl/bottom_mux_stage.sv - EX-stage destination register select with registered EX/MEM copy
module bottom_mux_stage #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             valid_in,
    input  logic             en,
    input  logic             flush,
    output logic [WIDTH-1:0] y,
    output logic             y_is_zero,
    output logic [WIDTH-1:0] y_q,
    output logic             valid_q,
    output logic             zero_q
);

    logic [WIDTH-1:0] w_y;
    logic             w_y_is_zero;
    logic [WIDTH-1:0] r_y_q;
    logic             r_valid_q;
    logic             r_zero_q;

    // An if on sel falls to the else branch for X/Z, so an unknown select picks b rather than X.
    always_comb begin
        w_y = b;
        if (sel == 1'b1) begin
            w_y = a;
        end
    end

    assign w_y_is_zero = (w_y == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q     <= '0;
            r_valid_q <= 1'b0;
            r_zero_q  <= 1'b0;
        end else if (flush) begin
            // A squashed slot looks like a write to $zero so downstream never commits it.
            r_y_q     <= '0;
            r_valid_q <= 1'b0;
            r_zero_q  <= 1'b1;
        end else if (en) begin
            r_y_q     <= w_y;
            r_valid_q <= valid_in;
            r_zero_q  <= w_y_is_zero;
        end
    end

    assign y         = w_y;
    assign y_is_zero = w_y_is_zero;
    assign y_q       = r_y_q;
    assign valid_q   = r_valid_q;
    assign zero_q    = r_zero_q;

endmodule

// File: tb/tb_bottom_mux_stage.sv
// tb/tb_bottom_mux_stage.sv - randomized and directed checks of bottom_mux_stage
module tb_bottom_mux_stage;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic         sel, valid_in, en, flush;
    logic [W-1:0] y, y_q;
    logic         y_is_zero, valid_q, zero_q;

    int vectors = 0;
    int errors  = 0;

    // reference state of the EX/MEM boundary
    logic [W-1:0] m_yq;
    logic         m_vq, m_zq;

    bottom_mux_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel),
        .valid_in(valid_in), .en(en), .flush(flush),
        .y(y), .y_is_zero(y_is_zero), .y_q(y_q),
        .valid_q(valid_q), .zero_q(zero_q)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        return (s === 1'b1) ? av : bv;
    endfunction

    // one rising edge; the model takes the inputs present at the edge, then outputs are sampled 1 later
    task automatic step();
        logic [W-1:0] sy;
        @(posedge clk);
        sy = pick(sel, a, b);
        if (!rst_n) begin
            m_yq = '0; m_vq = 1'b0; m_zq = 1'b0;
        end else if (flush) begin
            m_yq = '0; m_vq = 1'b0; m_zq = 1'b1;
        end else if (en) begin
            m_yq = sy; m_vq = valid_in; m_zq = (sy == 0);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a = '0; b = '0; sel = 1'b0; valid_in = 1'b0; en = 1'b0; flush = 1'b0;
        m_yq = '0; m_vq = 1'b0; m_zq = 1'b0;
        #1;
        vectors++;
        if (y_q !== '0 || valid_q !== 1'b0 || zero_q !== 1'b0) begin
            errors++;
            $display("FAIL reset: y_q=%b valid_q=%b zero_q=%b, required 00000 0 0", y_q, valid_q, zero_q);
        end
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_comb_select();
        a = 5'b01010; b = 5'b10101; sel = 1'b1;
        #1;
        vectors++;
        if (y !== 5'b01010 || y_is_zero !== 1'b0) begin
            errors++;
            $display("FAIL sel_a: y=%b zero=%b, required 01010 0", y, y_is_zero);
        end
        a = 5'b00000;
        #1;
        vectors++;
        if (y !== 5'b00000 || y_is_zero !== 1'b1) begin
            errors++;
            $display("FAIL sel_a_zero: y=%b zero=%b, required 00000 1", y, y_is_zero);
        end
    endtask

    task automatic test_select_b();
        a = 5'b00101; b = 5'b11101; sel = 1'b0;
        #1;
        vectors++;
        if (y !== 5'b11101) begin
            errors++;
            $display("FAIL sel_b: y=%b, required 11101", y);
        end
        sel = 1'bx;
        #1;
        vectors++;
        if (y !== pick(sel, a, b)) begin
            errors++;
            $display("FAIL sel_x: y=%b, required %b", y, pick(sel, a, b));
        end
        sel = 1'b0;
    endtask

    task automatic test_capture();
        step();
        en = 1'b1; valid_in = 1'b1; sel = 1'b1; a = 5'b11111; flush = 1'b0;
        step();
        vectors++;
        if (y_q !== 5'b11111 || valid_q !== 1'b1 || zero_q !== 1'b0) begin
            errors++;
            $display("FAIL capture: y_q=%b v=%b z=%b, required 11111 1 0", y_q, valid_q, zero_q);
        end
    endtask

    task automatic test_stall();
        en = 1'b0; a = 5'b00011;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (y_q !== 5'b11111 || valid_q !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: y_q=%b v=%b, required 11111 1", i, y_q, valid_q);
            end
        end
        en = 1'b1;
        step();
        vectors++;
        if (y_q !== 5'b00011 || zero_q !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: y_q=%b z=%b, required 00011 0", y_q, zero_q);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1; en = 1'b1; b = 5'b10000; sel = 1'b0;
        step();
        vectors++;
        if (valid_q !== 1'b0 || y_q !== '0 || zero_q !== 1'b1) begin
            errors++;
            $display("FAIL flush: v=%b y_q=%b z=%b, required 0 00000 1", valid_q, y_q, zero_q);
        end
        flush = 1'b0;
        step();
        vectors++;
        if (y_q !== 5'b10000 || valid_q !== 1'b1 || zero_q !== 1'b0) begin
            errors++;
            $display("FAIL after_flush: y_q=%b v=%b z=%b, required 10000 1 0", y_q, valid_q, zero_q);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; valid_in = 1'b1; sel = 1'b1; a = 5'b01101;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (y_q !== '0 || valid_q !== 1'b0 || zero_q !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: y_q=%b v=%b z=%b, required 00000 0 0", y_q, valid_q, zero_q);
        end
        m_yq = '0; m_vq = 1'b0; m_zq = 1'b0;
        a = 5'b10011;
        #1;
        vectors++;
        if (y !== 5'b10011 || y_is_zero !== 1'b0) begin
            errors++;
            $display("FAIL comb_in_reset: y=%b zero=%b, required 10011 0", y, y_is_zero);
        end
        step();
        vectors++;
        if (y_q !== '0 || valid_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: y_q=%b v=%b, required 00000 0", y_q, valid_q);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (y_q !== 5'b10011 || valid_q !== 1'b1 || zero_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: y_q=%b v=%b z=%b, required 10011 1 0", y_q, valid_q, zero_q);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ey;
        for (int i = 0; i < 300; i++) begin
            a        = W'($urandom_range(0, 31));
            b        = (($urandom & 3) == 0) ? '0 : W'($urandom_range(0, 31));
            sel      = 1'($urandom);
            valid_in = 1'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            #1;
            ey = pick(sel, a, b);
            vectors++;
            if (y !== ey || y_is_zero !== (ey == 0)) begin
                errors++;
                $display("FAIL rand_comb[%0d]: y=%b zero=%b, required %b %b", i, y, y_is_zero, ey, (ey == 0));
            end
            step();
            vectors++;
            if (y_q !== m_yq || valid_q !== m_vq || zero_q !== m_zq) begin
                errors++;
                $display("FAIL rand_reg[%0d]: y_q=%b v=%b z=%b, required %b %b %b",
                         i, y_q, valid_q, zero_q, m_yq, m_vq, m_zq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_comb_select();
        test_select_b();
        test_capture();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
